// File: rtl/timer_cfg_sequencer.sv
// AXI4-Lite master that writes NUM_REGS config words into the timer register bank.
// Define TIMER_CFG_READBACK_EN to read every register back and compare it with the written value.
module timer_cfg_sequencer #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            start,
    input  logic [NUM_REGS*32-1:0]          cfg_data,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [3:0]                      err_index,
    output logic [1:0]                      err_code,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int               IDX_W = $clog2(NUM_REGS + 1);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_REGS - 1);

    localparam logic [1:0] ERR_BRESP    = 2'b01;
    localparam logic [1:0] ERR_RRESP    = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH
    } state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        idx;
    logic [NUM_REGS*32-1:0]  shadow;
    logic                    aw_done, w_done;
    logic [31:0]             cur_word;
    logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr;
    logic                    aw_hs, w_hs;

    assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
    assign reg_addr = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx == IDX_W'(i)) cur_word = shadow[32*i +: 32];
    end

    // Address and data derive from idx, which only moves in the response states,
    // so both stay stable for as long as a VALID is held.
    assign busy          = (state != IDLE) && (state != FINISH);
    assign done          = (state == FINISH);
    assign M_AXI_AWADDR  = reg_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (state == WR_REQ) && !aw_done;
    assign M_AXI_WDATA   = cur_word;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (state == WR_REQ) && !w_done;
    assign M_AXI_BREADY  = (state == WR_RESP);
    assign M_AXI_ARPROT  = 3'b000;

`ifdef TIMER_CFG_READBACK_EN
    logic rd_bad;
    assign rd_bad        = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != cur_word);
    assign M_AXI_ARADDR  = reg_addr;
    assign M_AXI_ARVALID = (state == RD_REQ);
    assign M_AXI_RREADY  = (state == RD_RESP);
`else
    logic unused_rd;
    assign unused_rd     = &{1'b0, M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;
`endif

    // NOTE: state is a flop, so it takes <=; blocking assignments here would race other clocked readers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: state_next gets its default first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WR_REQ;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
            WR_RESP: if (M_AXI_BVALID) begin
                if (M_AXI_BRESP != 2'b00) state_next = FINISH;
                else if (idx != LAST)     state_next = WR_REQ;
`ifdef TIMER_CFG_READBACK_EN
                else                      state_next = RD_REQ;
`else
                else                      state_next = FINISH;
`endif
            end
`ifdef TIMER_CFG_READBACK_EN
            RD_REQ:  if (M_AXI_ARREADY) state_next = RD_RESP;
            RD_RESP: if (M_AXI_RVALID)
                state_next = (rd_bad || idx == LAST) ? FINISH : RD_REQ;
`endif
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the shadow vector is reset too, so data presented before the first start is a known zero.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            idx       <= '0;
            shadow    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'b00;
            err_index <= 4'd0;
        end else begin
            aw_done <= (state == WR_REQ) && (state_next == WR_REQ) && (aw_done || aw_hs);
            w_done  <= (state == WR_REQ) && (state_next == WR_REQ) && (w_done || w_hs);
            case (state)
                IDLE: if (start) begin
                    shadow    <= cfg_data;
                    idx       <= '0;
                    error     <= 1'b0;
                    err_code  <= 2'b00;
                    err_index <= 4'd0;
                end
                WR_RESP: if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        error     <= 1'b1;
                        err_code  <= ERR_BRESP;
                        err_index <= 4'(idx);
                    end else begin
                        idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
                    end
                end
`ifdef TIMER_CFG_READBACK_EN
                RD_RESP: if (M_AXI_RVALID) begin
                    if (rd_bad) begin
                        error     <= 1'b1;
                        err_code  <= (M_AXI_RRESP != 2'b00) ? ERR_RRESP : ERR_MISMATCH;
                        err_index <= 4'(idx);
                    end else if (idx != LAST) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
// Directed bench for timer_cfg_sequencer: behavioural AXI4-Lite slave with configurable
// AWREADY delay, BRESP error injection and read-data corruption.
module tb_timer_cfg_sequencer;

    localparam int NUM_REGS = 4;
`ifdef TIMER_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         start = 1'b0;
    logic [127:0] cfg_data = '0;
    logic         busy, done, error;
    logic [3:0]   err_index;
    logic [1:0]   err_code;
    logic [31:0]  M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]   M_AXI_WSTRB;
    logic [1:0]   M_AXI_BRESP, M_AXI_RRESP;
    logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic         M_AXI_RVALID, M_AXI_RREADY;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    timer_cfg_sequencer #(.NUM_REGS(NUM_REGS)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_index(err_index), .err_code(err_code),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // ---------------- behavioural slave ----------------
    int aw_delay = 0;          // AWREADY rises once AWVALID has waited this many cycles
    int bresp_err_idx = -1;    // register index answered with SLVERR
    int corrupt_idx = -1;      // register index whose read returns 0xDEAD
    int aw_cnt = 0;
    int aw_count = 0, w_count = 0, ar_count = 0;
    int awv_cycles = 0, wv_cycles = 0, done_count = 0;
    logic [31:0] mem [NUM_REGS];
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] lat_addr = '0, lat_data = '0;
    logic [31:0] cur_waddr, cur_wdata;
    int          widx, ridx;

    assign M_AXI_AWREADY = (aw_cnt >= aw_delay);
    assign M_AXI_WREADY  = 1'b1;
    assign M_AXI_ARREADY = 1'b1;
    assign cur_waddr     = (M_AXI_AWVALID && M_AXI_AWREADY) ? M_AXI_AWADDR : lat_addr;
    assign cur_wdata     = (M_AXI_WVALID && M_AXI_WREADY) ? M_AXI_WDATA : lat_data;
    assign widx          = int'(cur_waddr[5:2]);
    assign ridx          = int'(M_AXI_ARADDR[5:2]);

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
            M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
        end else begin
            if (M_AXI_AWVALID) awv_cycles <= awv_cycles + 1;
            if (M_AXI_WVALID)  wv_cycles  <= wv_cycles + 1;
            if (done)          done_count <= done_count + 1;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_cnt <= 0; aw_count <= aw_count + 1; lat_addr <= M_AXI_AWADDR;
            end else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_count <= w_count + 1; lat_data <= M_AXI_WDATA;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if ((aw_got || (M_AXI_AWVALID && M_AXI_AWREADY)) &&
                (w_got || (M_AXI_WVALID && M_AXI_WREADY))) begin
                M_AXI_BVALID <= 1'b1;
                M_AXI_BRESP  <= (widx == bresp_err_idx) ? 2'b10 : 2'b00;
                mem[widx]    <= cur_wdata;
                aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_got <= 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY)   w_got  <= 1'b1;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                ar_count     <= ar_count + 1;
                M_AXI_RVALID <= 1'b1;
                M_AXI_RRESP  <= 2'b00;
                M_AXI_RDATA  <= (ridx == corrupt_idx) ? 32'h0000_DEAD : mem[ridx];
            end else if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
        end
    end

    // Pulse start for one cycle (cycle 1) and count cycles until done is seen; 0 on timeout.
    task automatic run_seq(output int cyc);
        @(negedge ACLK); start = 1'b1; cyc = 1;
        @(negedge ACLK); start = 1'b0; cyc = 2;
        while (!done && cyc < 300) begin @(negedge ACLK); cyc++; end
        if (!done) cyc = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++;
            $display("FAIL reset_flags: busy/done/error = %b%b%b, expected 000", busy, done, error); end
        checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin errors++;
            $display("FAIL reset_axi: valid/ready = %b, expected 00000",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}); end
        checks++; if (err_code !== 2'b00 || err_index !== 4'd0) begin errors++;
            $display("FAIL reset_err: code=%b index=%0d, expected 00/0", err_code, err_index); end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        checks++; if (busy !== 1'b0 || M_AXI_AWVALID !== 1'b0) begin errors++;
            $display("FAIL idle_after_reset: busy=%b awvalid=%b, expected 0/0", busy, M_AXI_AWVALID); end
        checks++; if (M_AXI_WSTRB !== 4'hF || M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) begin errors++;
            $display("FAIL static_fields: wstrb=%h awprot=%b arprot=%b, expected f/000/000",
                     M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT); end
    endtask

    task automatic test_zero_wait();
        int cyc, aw0, w0, ar0, d0;
        logic [127:0] cfg;
        cfg = {32'd4, 32'd3, 32'd2, 32'd1};
        cfg_data = cfg;
        aw0 = aw_count; w0 = w_count; ar0 = ar_count; d0 = done_count;
        run_seq(cyc);
        checks++; if (cyc !== (RB ? 18 : 10)) begin errors++;
            $display("FAIL zw_latency: done at cycle %0d, expected %0d", cyc, RB ? 18 : 10); end
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin errors++;
            $display("FAIL zw_status: busy=%b error=%b while done, expected 0/0", busy, error); end
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++; if (mem[i] !== cfg[32*i +: 32]) begin errors++;
                $display("FAIL zw_reg%0d: slave holds %h, expected %h", i, mem[i], cfg[32*i +: 32]); end
        end
        checks++; if (aw_count - aw0 !== 4 || w_count - w0 !== 4) begin errors++;
            $display("FAIL zw_beats: aw=%0d w=%0d, expected 4/4", aw_count - aw0, w_count - w0); end
        checks++; if (ar_count - ar0 !== (RB ? 4 : 0)) begin errors++;
            $display("FAIL zw_reads: %0d reads, expected %0d", ar_count - ar0, RB ? 4 : 0); end
        @(negedge ACLK);
        checks++; if (done !== 1'b0 || done_count - d0 !== 1) begin errors++;
            $display("FAIL zw_done_pulse: done=%b pulses=%0d, expected 0/1", done, done_count - d0); end
    endtask

    task automatic test_aw_delay();
        int cyc, awv0, wv0, w0;
        logic [127:0] cfg;
        cfg = {32'hA4A4_0004, 32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001};
        cfg_data = cfg; aw_delay = 2;
        awv0 = awv_cycles; wv0 = wv_cycles; w0 = w_count;
        run_seq(cyc);
        checks++; if (cyc !== (RB ? 26 : 18)) begin errors++;
            $display("FAIL awd_latency: done at cycle %0d, expected %0d", cyc, RB ? 26 : 18); end
        checks++; if (awv_cycles - awv0 !== 12 || wv_cycles - wv0 !== 4) begin errors++;
            $display("FAIL awd_valid_cycles: awvalid=%0d wvalid=%0d, expected 12/4",
                     awv_cycles - awv0, wv_cycles - wv0); end
        checks++; if (w_count - w0 !== 4 || error !== 1'b0) begin errors++;
            $display("FAIL awd_wbeats: w=%0d error=%b, expected 4/0", w_count - w0, error); end
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++; if (mem[i] !== cfg[32*i +: 32]) begin errors++;
                $display("FAIL awd_reg%0d: slave holds %h, expected %h", i, mem[i], cfg[32*i +: 32]); end
        end
        aw_delay = 0;
    endtask

    task automatic test_bresp_error();
        int cyc, aw0, ar0;
        cfg_data = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
        bresp_err_idx = 2;
        aw0 = aw_count; ar0 = ar_count;
        run_seq(cyc);
        checks++; if (cyc !== 8) begin errors++;
            $display("FAIL bresp_latency: done at cycle %0d, expected 8", cyc); end
        checks++; if (error !== 1'b1 || err_code !== 2'b01 || err_index !== 4'd2) begin errors++;
            $display("FAIL bresp_err: error=%b code=%b index=%0d, expected 1/01/2", error, err_code, err_index); end
        repeat (5) @(negedge ACLK);
        checks++; if (aw_count - aw0 !== 3 || ar_count - ar0 !== 0) begin errors++;
            $display("FAIL bresp_abort: aw=%0d ar=%0d, expected 3/0", aw_count - aw0, ar_count - ar0); end
        checks++; if (error !== 1'b1) begin errors++;
            $display("FAIL bresp_sticky: error=%b, expected 1", error); end
        bresp_err_idx = -1;
    endtask

`ifdef TIMER_CFG_READBACK_EN
    task automatic test_mismatch();
        int cyc, ar0;
        cfg_data = {32'hC4, 32'hC3, 32'hC2, 32'hC1};
        corrupt_idx = 1;
        ar0 = ar_count;
        run_seq(cyc);
        checks++; if (cyc !== 14) begin errors++;
            $display("FAIL mm_latency: done at cycle %0d, expected 14", cyc); end
        checks++; if (error !== 1'b1 || err_code !== 2'b11 || err_index !== 4'd1) begin errors++;
            $display("FAIL mm_err: error=%b code=%b index=%0d, expected 1/11/1", error, err_code, err_index); end
        checks++; if (ar_count - ar0 !== 2) begin errors++;
            $display("FAIL mm_reads: %0d reads, expected 2", ar_count - ar0); end
        corrupt_idx = -1;
    endtask
`endif

    task automatic test_back_to_back();
        int cyc, aw0, d0;
        logic [127:0] cfg;
        cfg_data = {32'hD4, 32'hD3, 32'hD2, 32'hD1};
        aw0 = aw_count; d0 = done_count;
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++;
            $display("FAIL b2b_accept: busy=%b error=%b, expected 1/0 (error cleared)", busy, error); end
        repeat (2) @(negedge ACLK);
        start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        repeat (60) @(negedge ACLK);
        checks++; if (done_count - d0 !== 1 || aw_count - aw0 !== 4) begin errors++;
            $display("FAIL b2b_ignored: done pulses=%0d aw=%0d, expected 1/4", done_count - d0, aw_count - aw0); end

        // Asynchronous reset while waiting for a write response.
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        cyc = 0;
        while (!M_AXI_BREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
        checks++; if (M_AXI_BREADY !== 1'b1) begin errors++;
            $display("FAIL rst_reach_wresp: bready=%b, expected 1", M_AXI_BREADY); end
        #2 ARESETN = 1'b0;
        #1;
        checks++; if ({busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID} !== 5'b0) begin errors++;
            $display("FAIL rst_async: busy/aw/w/b/ar = %b, expected 00000",
                     {busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID}); end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        cfg = {32'hE4, 32'hE3, 32'hE2, 32'hE1};
        cfg_data = cfg;
        run_seq(cyc);
        checks++; if (cyc !== (RB ? 18 : 10) || error !== 1'b0) begin errors++;
            $display("FAIL rst_rerun: done at cycle %0d error=%b, expected %0d/0", cyc, error, RB ? 18 : 10); end
        checks++; if (mem[3] !== cfg[127:96] || mem[0] !== cfg[31:0]) begin errors++;
            $display("FAIL rst_rerun_data: reg0=%h reg3=%h, expected %h/%h", mem[0], mem[3], cfg[31:0], cfg[127:96]); end
    endtask

    task automatic test_snapshot();
        int cyc;
        logic [127:0] cfg_a;
        cfg_a = {32'h1111_0004, 32'h1111_0003, 32'h1111_0002, 32'h1111_0001};
        cfg_data = cfg_a;
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        cfg_data = {32'h2222_0004, 32'h2222_0003, 32'h2222_0002, 32'h2222_0001};
        cyc = 0;
        while (!done && cyc < 300) begin @(negedge ACLK); cyc++; end
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++;
            $display("FAIL snap_done: done=%b error=%b, expected 1/0", done, error); end
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++; if (mem[i] !== cfg_a[32*i +: 32]) begin errors++;
                $display("FAIL snap_reg%0d: slave holds %h, expected %h", i, mem[i], cfg_a[32*i +: 32]); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_aw_delay();
        test_bresp_error();
`ifdef TIMER_CFG_READBACK_EN
        test_mismatch();
`endif
        test_back_to_back();
        test_snapshot();
        repeat (3) @(negedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
